load_extend_unit: RTL and testbench

Load-data alignment and extension stage for the single-cycle datapath's data memory read path. It takes the raw 32-bit word read from data memory plus the byte offset and access size. It selects the addressed byte or halfword and zero- or sign-extends it to 32 bits. The result is registered with a valid flag and a misalignment flag for the writeback mux.

---
 rtl/load_extend_unit_pkg.sv | 38 +++
 rtl/load_extend_unit_width_extender.sv | 36 +++
 rtl/load_extend_unit.sv | 120 ++++++++++++
 tb/tb_load_extend_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/load_extend_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_extend_unit_pkg
// Shared encodings for the data-memory load alignment/extension stage.
//   mem_op_e  : access size carried on mem_op
//   ext_op_e  : zero/sign extension select carried on mem_ext
//   WORD_W    : width of a memory word and of every extended result
//   is_legal_load() : true when a size/offset pair is a legal request
// -----------------------------------------------------------------------------
package load_extend_unit_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MEM_WORD = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_RSVD = 2'b11
    } mem_op_e;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_op_e;

    // Halfwords must sit on an even byte; the reserved size is never legal.
    function automatic logic is_legal_load(input logic [1:0] op, input logic [1:0] off);
        logic legal;
        case (op)
            MEM_WORD: legal = 1'b1;
            MEM_BYTE: legal = 1'b1;
            MEM_HALF: legal = (off[0] == 1'b0);
            MEM_RSVD: legal = 1'b0;
            default:  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : load_extend_unit_pkg

// File: rtl/load_extend_unit_width_extender.sv
// -----------------------------------------------------------------------------
// width_extender
// Purely combinational zero/sign extension of an IN_W-bit field to WORD_W bits.
// Ports:
//   i_in     [IN_W-1:0]   field to extend (already aligned to bit 0)
//   i_ext_op              EXT_ZERO or EXT_SIGN
//   o_out    [WORD_W-1:0] extended value
// -----------------------------------------------------------------------------
module width_extender
    import load_extend_unit_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0]   i_in,
    input  logic              i_ext_op,
    output logic [WORD_W-1:0] o_out
);

    logic w_fill;

    // Fill bit is the field MSB only for sign extension.
    always_comb begin
        w_fill = 1'b0;
        if (i_ext_op == EXT_SIGN) begin
            w_fill = i_in[IN_W-1];
        end else begin
            w_fill = 1'b0;
        end
    end

    // Replicate the fill bit above the field.
    always_comb begin
        o_out = {{(WORD_W-IN_W){w_fill}}, i_in};
    end

endmodule : width_extender

// File: rtl/load_extend_unit.sv
// -----------------------------------------------------------------------------
// load_extend_unit
// Load-data alignment and extension for the data-memory read path. Selects the
// addressed byte/halfword from the raw little-endian word, extends it to 32
// bits and registers the result with a valid and a misalignment flag.
// Ports:
//   clk       clock, all state on rising edge
//   rst       synchronous active-high reset (wins over in_valid)
//   in_valid  one load request per asserted cycle
//   mem_op    [1:0] access size (word/byte/half/reserved)
//   mem_ext   0 = zero-extend, 1 = sign-extend
//   byte_off  [1:0] address[1:0]
//   rdata     [31:0] raw word from data memory
//   out_valid registered result valid, one cycle after the request
//   dout      [31:0] aligned, extended result (holds when idle)
//   misalign  request was a halfword at an odd offset or a reserved size
// -----------------------------------------------------------------------------
module load_extend_unit
    import load_extend_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        mem_op,
    input  logic              mem_ext,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout,
    output logic              misalign
);

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_byte_ext;
    logic [DATA_W-1:0] w_half_ext;
    logic [DATA_W-1:0] w_dout;
    logic              w_misalign;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_dout;
    logic              r_misalign;

    // Little-endian byte lane select.
    always_comb begin
        w_byte = 8'h00;
        case (byte_off)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    // Halfword lane select; only offset bit 1 matters, odd offsets are flagged later.
    always_comb begin
        w_half = 16'h0000;
        if (byte_off[1]) begin
            w_half = rdata[31:16];
        end else begin
            w_half = rdata[15:0];
        end
    end

    width_extender #(
        .IN_W (8)
    ) u_byte_ext (
        .i_in     (w_byte),
        .i_ext_op (mem_ext),
        .o_out    (w_byte_ext)
    );

    width_extender #(
        .IN_W (16)
    ) u_half_ext (
        .i_in     (w_half),
        .i_ext_op (mem_ext),
        .o_out    (w_half_ext)
    );

    // Choose the result by access size; illegal requests produce zero data.
    always_comb begin
        w_dout     = {DATA_W{1'b0}};
        w_misalign = ~is_legal_load(mem_op, byte_off);
        if (w_misalign) begin
            w_dout = {DATA_W{1'b0}};
        end else begin
            case (mem_op)
                MEM_WORD: w_dout = rdata;
                MEM_BYTE: w_dout = w_byte_ext;
                MEM_HALF: w_dout = w_half_ext;
                MEM_RSVD: w_dout = {DATA_W{1'b0}};
                default:  w_dout = {DATA_W{1'b0}};
            endcase
        end
    end

    // Output register: data and flag load only on a request and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dout      <= {DATA_W{1'b0}};
            r_misalign  <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_dout     <= w_dout;
                r_misalign <= w_misalign;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign misalign  = r_misalign;

endmodule : load_extend_unit

// File: tb/tb_load_extend_unit.sv
module tb_load_extend_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  mem_op;
    logic        mem_ext;
    logic [1:0]  byte_off;
    logic [31:0] rdata;
    logic        out_valid;
    logic [31:0] dout;
    logic        misalign;

    int n_vec;
    int n_err;

    load_extend_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mem_op    (mem_op),
        .mem_ext   (mem_ext),
        .byte_off  (byte_off),
        .rdata     (rdata),
        .out_valid (out_valid),
        .dout      (dout),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge so they are stable at the next rising edge.
    task automatic drive(input logic v, input logic [1:0] op, input logic ext,
                         input logic [1:0] off, input logic [31:0] d);
        @(negedge clk);
        in_valid = v;
        mem_op   = op;
        mem_ext  = ext;
        byte_off = off;
        rdata    = d;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 2'd0, 32'hFFFFFFFF);
        settle();
        n_vec++;
        if (out_valid !== 1'b0 || dout !== 32'h0 || misalign !== 1'b0) begin
            $display("FAIL reset: got v=%b d=%h m=%b want v=0 d=00000000 m=0", out_valid, dout, misalign);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_byte();
        logic [31:0] exp_sign [4];
        logic [31:0] exp_zero [4];
        exp_sign = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
        exp_zero = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, 1'b1, i[1:0], 32'h80FF7F01);
            settle();
            n_vec++;
            if (out_valid !== 1'b1 || dout !== exp_sign[i] || misalign !== 1'b0) begin
                $display("FAIL byte_sign off=%0d: got v=%b d=%h m=%b want v=1 d=%h m=0", i, out_valid, dout, misalign, exp_sign[i]);
                n_err++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, 1'b0, i[1:0], 32'h80FF7F01);
            settle();
            n_vec++;
            if (out_valid !== 1'b1 || dout !== exp_zero[i] || misalign !== 1'b0) begin
                $display("FAIL byte_zero off=%0d: got v=%b d=%h m=%b want v=1 d=%h m=0", i, out_valid, dout, misalign, exp_zero[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_half();
        logic        ext_t [4];
        logic [1:0]  off_t [4];
        logic [31:0] exp_t [4];
        ext_t = '{1'b1, 1'b1, 1'b0, 1'b0};
        off_t = '{2'd0, 2'd2, 2'd2, 2'd0};
        exp_t = '{32'h00007FFF, 32'hFFFF8001, 32'h00008001, 32'h00007FFF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, ext_t[i], off_t[i], 32'h80017FFF);
            settle();
            n_vec++;
            if (out_valid !== 1'b1 || dout !== exp_t[i] || misalign !== 1'b0) begin
                $display("FAIL half case%0d: got v=%b d=%h m=%b want v=1 d=%h m=0", i, out_valid, dout, misalign, exp_t[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_misalign();
        logic [1:0] op_t  [4];
        logic [1:0] off_t [4];
        op_t  = '{2'b10, 2'b10, 2'b11, 2'b11};
        off_t = '{2'd1, 2'd3, 2'd0, 2'd2};
        for (int i = 0; i < 4; i++) begin
            // Precede each with a legal word so dout is known non-zero beforehand.
            drive(1'b1, 2'b00, 1'b0, 2'd0, 32'hCAFEF00D);
            settle();
            drive(1'b1, op_t[i], 1'b1, off_t[i], 32'h12345678);
            settle();
            n_vec++;
            if (out_valid !== 1'b1 || dout !== 32'h0 || misalign !== 1'b1) begin
                $display("FAIL misalign case%0d: got v=%b d=%h m=%b want v=1 d=00000000 m=1", i, out_valid, dout, misalign);
                n_err++;
            end
        end
    endtask

    task automatic test_word();
        drive(1'b1, 2'b00, 1'b1, 2'd3, 32'hDEADBEEF);
        settle();
        n_vec++;
        if (out_valid !== 1'b1 || dout !== 32'hDEADBEEF || misalign !== 1'b0) begin
            $display("FAIL word: got v=%b d=%h m=%b want v=1 d=deadbeef m=0", out_valid, dout, misalign);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op_t  [4];
        logic        ext_t [4];
        logic [1:0]  off_t [4];
        logic [31:0] d_t   [4];
        logic [31:0] exp_t [4];
        logic        mis_t [4];
        op_t  = '{2'b01, 2'b10, 2'b10, 2'b00};
        ext_t = '{1'b1, 1'b1, 1'b0, 1'b0};
        off_t = '{2'd1, 2'd3, 2'd0, 2'd1};
        d_t   = '{32'h0000A500, 32'h12345678, 32'h0000F00F, 32'h01020304};
        exp_t = '{32'hFFFFFFA5, 32'h00000000, 32'h0000F00F, 32'h01020304};
        mis_t = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, op_t[i], ext_t[i], off_t[i], d_t[i]);
            settle();
            n_vec++;
            if (out_valid !== 1'b1 || dout !== exp_t[i] || misalign !== mis_t[i]) begin
                $display("FAIL b2b req%0d: got v=%b d=%h m=%b want v=1 d=%h m=%b", i, out_valid, dout, misalign, exp_t[i], mis_t[i]);
                n_err++;
            end
        end
        // Idle cycle with different inputs present: valid drops, data holds.
        drive(1'b0, 2'b01, 1'b1, 2'd0, 32'hFFFFFFFF);
        settle();
        n_vec++;
        if (out_valid !== 1'b0 || dout !== 32'h01020304 || misalign !== 1'b0) begin
            $display("FAIL idle_hold: got v=%b d=%h m=%b want v=0 d=01020304 m=0", out_valid, dout, misalign);
            n_err++;
        end
        // Misaligned result then idle: the flag must hold too.
        drive(1'b1, 2'b11, 1'b0, 2'd0, 32'h12345678);
        settle();
        drive(1'b0, 2'b00, 1'b0, 2'd0, 32'h11111111);
        settle();
        n_vec++;
        if (out_valid !== 1'b0 || dout !== 32'h0 || misalign !== 1'b1) begin
            $display("FAIL idle_hold_mis: got v=%b d=%h m=%b want v=0 d=00000000 m=1", out_valid, dout, misalign);
            n_err++;
        end
        // Reset mid-stream while a request is also presented.
        drive(1'b1, 2'b00, 1'b0, 2'd0, 32'h55AA55AA);
        settle();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        rdata    = 32'h77777777;
        settle();
        n_vec++;
        if (out_valid !== 1'b0 || dout !== 32'h0 || misalign !== 1'b0) begin
            $display("FAIL midstream_rst: got v=%b d=%h m=%b want v=0 d=00000000 m=0", out_valid, dout, misalign);
            n_err++;
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        mem_op   = 2'b00;
        mem_ext  = 1'b0;
        byte_off = 2'd0;
        rdata    = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_byte();
        test_half();
        test_misalign();
        test_word();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_load_extend_unit
